// File: rtl/pri_req_arbiter.sv
// pri_req_arbiter
//   Shares one downstream resource among eight active-low requesters.
//   A winner is picked in IDLE and registered. Its grant is held in GRANT
//   until the owner strobes iDone. One RELEASE cycle then separates that
//   grant from the next arbitration.
//
//   Fixed priority is used by default: the highest active index wins.
//   Define ARB_ROUND_ROBIN_EN to rotate the search order instead. The search
//   then starts just below the last granted index and checks that index last.
//
// Ports
//   iClk      in   clock, rising edge
//   iRst_n    in   asynchronous active-low reset
//   iReq_n    in   [7:0] request lines, active-low, level-sensitive
//   iEI       in   inhibit; 1 blocks new grants
//   iDone     in   completion strobe from the owner, honoured only in GRANT
//   oGnt_n    out  [7:0] one-hot active-low grant, 8'hFF when no grant
//   oId       out  [2:0] index of the current owner, 0 when idle
//   oBusy     out  1 while in GRANT
//   oEO       out  enable-out: IDLE with no inhibit and no request (combinational)
//   oCnt      out  [7:0] completed-grant count, wraps 255 -> 0
//   oState    out  [1:0] FSM state for observation (0 IDLE, 1 GRANT, 2 RELEASE)
module pri_req_arbiter (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [7:0] iReq_n,
    input  logic       iEI,
    input  logic       iDone,
    output logic [7:0] oGnt_n,
    output logic [2:0] oId,
    output logic       oBusy,
    output logic       oEO,
    output logic [7:0] oCnt,
    output logic [1:0] oState
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] gnt_n_q, gnt_n_d;
    logic [2:0] id_q, id_d;
    logic       busy_q, busy_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] win;
    logic       any_req;

    assign any_req = (iReq_n != 8'hFF);

`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] cand;

    // The loop runs from the farthest offset toward the nearest. Each hit
    // overrides the previous one, so the nearest offset below the pointer
    // wins. Offset 8 wraps to the pointer itself, which makes it the last
    // choice.
    always_comb begin
        win  = 3'd0;
        cand = 3'd0;
        for (int off = 8; off >= 1; off--) begin
            cand = ptr_q - 3'(off);
            if (!iReq_n[cand]) begin
                win = cand;
            end
        end
    end
`else
    // Ascending scan: a later (higher) active index overrides an earlier one.
    always_comb begin
        win = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!iReq_n[i]) begin
                win = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_n_d = gnt_n_q;
        id_d    = id_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!iEI && any_req) begin
                    state_d = ST_GRANT;
                    gnt_n_d = ~(8'h01 << win);
                    id_d    = win;
                    busy_d  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = win;
`endif
                end
            end
            ST_GRANT: begin
                // The grant is held regardless of iReq_n or iEI. Only the
                // owner's iDone ends it.
                if (iDone) begin
                    state_d = ST_RELEASE;
                    gnt_n_d = 8'hFF;
                    id_d    = 3'd0;
                    busy_d  = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_n_d = 8'hFF;
                id_d    = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            gnt_n_q <= 8'hFF;
            id_q    <= 3'd0;
            busy_q  <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            gnt_n_q <= gnt_n_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign oGnt_n = gnt_n_q;
    assign oId    = id_q;
    assign oBusy  = busy_q;
    assign oCnt   = cnt_q;
    assign oState = state_q;
    assign oEO    = (state_q == ST_IDLE) && !iEI && !any_req;

endmodule

// File: tb/tb_pri_req_arbiter.sv
// Bench for pri_req_arbiter.
// Each step drives inputs at the falling edge and pushes the expected
// outputs. It then samples the outputs 1 ns after the next rising edge and
// compares them against the popped entry.
// Expected word layout: {state[1:0], gnt_n[7:0], id[2:0], busy, eo, cnt[7:0]}.
module tb_pri_req_arbiter;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_n;
    logic       ei;
    logic       done;
    logic [7:0] gnt_n;
    logic [2:0] id;
    logic       busy;
    logic       eo;
    logic [7:0] cnt;
    logic [1:0] state;

    logic [22:0] exp_q[$];
    int          n_cmp;
    int          n_mis;
    logic [7:0]  model_cnt;

    typedef struct {
        logic [7:0]  req_n;
        logic        ei;
        logic        done;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];

    pri_req_arbiter dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iReq_n (req_n),
        .iEI    (ei),
        .iDone  (done),
        .oGnt_n (gnt_n),
        .oId    (id),
        .oBusy  (busy),
        .oEO    (eo),
        .oCnt   (cnt),
        .oState (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [22:0] mk(input logic [1:0] st, input logic [7:0] g,
                                       input logic [2:0] i, input logic b,
                                       input logic e, input logic [7:0] c);
        return {st, g, i, b, e, c};
    endfunction

    function automatic vec_t v(input logic [7:0] r, input logic e_i, input logic d,
                               input logic [22:0] x);
        vec_t t;
        t.req_n = r;
        t.ei    = e_i;
        t.done  = d;
        t.exp   = x;
        return t;
    endfunction

    // scoreboard compare: pops the oldest expectation
    task automatic check(input string name);
        logic [22:0] got;
        logic [22:0] e;
        got = {state, gnt_n, id, busy, eo, cnt};
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s: scoreboard empty, got=%h", name, got);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_mis++;
                $display("FAIL %s: got st=%0d gnt_n=%h id=%0d busy=%b eo=%b cnt=%h, want st=%0d gnt_n=%h id=%0d busy=%b eo=%b cnt=%h",
                         name, got[22:21], got[20:13], got[12:10], got[9], got[8], got[7:0],
                         e[22:21], e[20:13], e[12:10], e[9], e[8], e[7:0]);
            end
        end
    endtask

    // driver: one clock per step
    task automatic step(input logic [7:0] r, input logic e_i, input logic d,
                        input logic [22:0] x, input string name);
        @(negedge clk);
        req_n = r;
        ei    = e_i;
        done  = d;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        req_n = 8'hFF;
        ei    = 1'b0;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(S_IDLE, 8'hFF, 3'd0, 1'b0, 1'b1, 8'h00));
        check("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

`ifndef ARB_ROUND_ROBIN_EN
        // fixed priority, release, inhibit, done in IDLE/RELEASE, done with new request
        vecs.push_back(v(8'hFF, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 1, 8'd0)));
        vecs.push_back(v(8'h5E, 0, 0, mk(S_GNT,  8'h7F, 7, 1, 0, 8'd0)));
        vecs.push_back(v(8'h5E, 0, 0, mk(S_GNT,  8'h7F, 7, 1, 0, 8'd0)));
        vecs.push_back(v(8'h5E, 0, 0, mk(S_GNT,  8'h7F, 7, 1, 0, 8'd0)));
        vecs.push_back(v(8'h5E, 0, 0, mk(S_GNT,  8'h7F, 7, 1, 0, 8'd0)));
        vecs.push_back(v(8'hDE, 0, 1, mk(S_REL,  8'hFF, 0, 0, 0, 8'd1)));
        vecs.push_back(v(8'hDE, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 0, 8'd1)));
        vecs.push_back(v(8'hDE, 0, 0, mk(S_GNT,  8'hDF, 5, 1, 0, 8'd1)));
        vecs.push_back(v(8'hDE, 0, 1, mk(S_REL,  8'hFF, 0, 0, 0, 8'd2)));
        vecs.push_back(v(8'hFF, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 1, 8'd2)));
        vecs.push_back(v(8'hFE, 1, 0, mk(S_IDLE, 8'hFF, 0, 0, 0, 8'd2)));
        vecs.push_back(v(8'hFE, 1, 0, mk(S_IDLE, 8'hFF, 0, 0, 0, 8'd2)));
        vecs.push_back(v(8'hFE, 0, 0, mk(S_GNT,  8'hFE, 0, 1, 0, 8'd2)));
        vecs.push_back(v(8'hFE, 0, 1, mk(S_REL,  8'hFF, 0, 0, 0, 8'd3)));
        vecs.push_back(v(8'hFF, 0, 1, mk(S_IDLE, 8'hFF, 0, 0, 1, 8'd3)));
        vecs.push_back(v(8'hFF, 0, 1, mk(S_IDLE, 8'hFF, 0, 0, 1, 8'd3)));
        vecs.push_back(v(8'hFB, 0, 0, mk(S_GNT,  8'hFB, 2, 1, 0, 8'd3)));
        vecs.push_back(v(8'h7F, 0, 0, mk(S_GNT,  8'hFB, 2, 1, 0, 8'd3)));
        vecs.push_back(v(8'h7F, 1, 0, mk(S_GNT,  8'hFB, 2, 1, 0, 8'd3)));
        vecs.push_back(v(8'h7F, 0, 1, mk(S_REL,  8'hFF, 0, 0, 0, 8'd4)));
        vecs.push_back(v(8'h7F, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 0, 8'd4)));
        vecs.push_back(v(8'h7F, 0, 0, mk(S_GNT,  8'h7F, 7, 1, 0, 8'd4)));
        vecs.push_back(v(8'hFF, 0, 1, mk(S_REL,  8'hFF, 0, 0, 0, 8'd5)));
        vecs.push_back(v(8'hFF, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 1, 8'd5)));
        model_cnt = 8'd5;
`else
        // round robin: requesters 7 and 0 alternate, 6..1 skipped
        vecs.push_back(v(8'hFF, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 1, 8'd0)));
        vecs.push_back(v(8'h7E, 0, 0, mk(S_GNT,  8'h7F, 7, 1, 0, 8'd0)));
        vecs.push_back(v(8'h7E, 0, 1, mk(S_REL,  8'hFF, 0, 0, 0, 8'd1)));
        vecs.push_back(v(8'h7E, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 0, 8'd1)));
        vecs.push_back(v(8'h7E, 0, 0, mk(S_GNT,  8'hFE, 0, 1, 0, 8'd1)));
        vecs.push_back(v(8'h7E, 0, 1, mk(S_REL,  8'hFF, 0, 0, 0, 8'd2)));
        vecs.push_back(v(8'h7E, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 0, 8'd2)));
        vecs.push_back(v(8'h7E, 0, 0, mk(S_GNT,  8'h7F, 7, 1, 0, 8'd2)));
        vecs.push_back(v(8'h7E, 0, 1, mk(S_REL,  8'hFF, 0, 0, 0, 8'd3)));
        vecs.push_back(v(8'h7E, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 0, 8'd3)));
        vecs.push_back(v(8'h7E, 0, 0, mk(S_GNT,  8'hFE, 0, 1, 0, 8'd3)));
        vecs.push_back(v(8'hFF, 0, 1, mk(S_REL,  8'hFF, 0, 0, 0, 8'd4)));
        vecs.push_back(v(8'hFF, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 1, 8'd4)));
        model_cnt = 8'd4;
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req_n, vecs[i].ei, vecs[i].done, vecs[i].exp,
                 $sformatf("vec%0d", i));
        end

        // hold, no preemption: requester 2 keeps the grant for 10 cycles
        step(8'hFB, 0, 0, mk(S_GNT, 8'hFB, 2, 1, 0, model_cnt), "hold_grant");
        for (int i = 0; i < 10; i++) begin
            step(8'h7F, 1'($urandom_range(0, 1)), 0,
                 mk(S_GNT, 8'hFB, 2, 1, 0, model_cnt), $sformatf("hold%0d", i));
        end
        model_cnt = model_cnt + 8'd1;
        step(8'h7F, 0, 1, mk(S_REL, 8'hFF, 0, 0, 0, model_cnt), "hold_release");
        step(8'hFF, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 1, model_cnt), "hold_idle");

        // reset in the middle of a grant to requester 3
        step(8'hF7, 0, 0, mk(S_GNT, 8'hF7, 3, 1, 0, model_cnt), "pre_reset_grant");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(S_IDLE, 8'hFF, 0, 0, 0, 8'd0));
        check("async_reset");
        @(negedge clk);
        req_n = 8'hFF;
        rst_n = 1'b1;
        model_cnt = 8'd0;
        step(8'hFF, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 1, 8'd0), "post_reset_idle");

        // 256 transactions with a random single requester; the count wraps to 0
        for (int t = 0; t < 256; t++) begin
            int k;
            logic [7:0] one_hot_n;
            k = $urandom_range(0, 7);
            one_hot_n = ~(8'h01 << k);
            step(one_hot_n, 0, 0, mk(S_GNT, one_hot_n, 3'(k), 1, 0, model_cnt),
                 $sformatf("wrap_gnt%0d", t));
            model_cnt = model_cnt + 8'd1;
            step(8'hFF, 0, 1, mk(S_REL, 8'hFF, 0, 0, 0, model_cnt),
                 $sformatf("wrap_rel%0d", t));
            step(8'hFF, 0, 0, mk(S_IDLE, 8'hFF, 0, 0, 1, model_cnt),
                 $sformatf("wrap_idle%0d", t));
        end
        // done pulses in IDLE leave the wrapped count at 0
        for (int i = 0; i < 3; i++) begin
            step(8'hFF, 0, 1, mk(S_IDLE, 8'hFF, 0, 0, 1, 8'h00),
                 $sformatf("idle_done%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
